spi_word_receiver: RTL and testbench

//  Parametrised SPI slave receive front end for node-to-node links. Synchronises raw sclk/cs_n/mosi into clk,

---
 rtl/spi_rx_pkg.sv | 31 +++
 rtl/spi_rx_sync.sv | 86 ++++++++
 rtl/spi_word_receiver.sv | 187 ++++++++++++++++++
 tb/tb_spi_word_receiver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rx_pkg
//  Purpose  : Shared types and helpers for the SPI word receiver: FSM state
//             encoding, sample-edge selection and the glitch-filter enable.
//  Config   : SPI_RX_DEBOUNCE_EN - when defined, sclk/cs_n pass through a
//             stable-sample filter and mosi is delayed to match.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_rx_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2
    } rx_state_t;

`ifdef SPI_RX_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif

    // Data is sampled on the sclk rising edge when CPOL equals CPHA,
    // otherwise on the falling edge.
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return (cpol == cpha);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rx_sync
//  Purpose  : One synchroniser chain for an asynchronous SPI line, followed by
//             either a stable-sample filter (FILTERED=1) or a matching delay
//             line (FILTERED=0) of FILTER_DEPTH cycles. FILTER_DEPTH is zero
//             unless SPI_RX_DEBOUNCE_EN is defined, so no extra logic remains.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_rx_sync #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_DEPTH = 0,
    parameter bit FILTERED     = 1'b0,
    parameter bit IDLE_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Metastability chain; reset loads the line's idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= {SYNC_STAGES{IDLE_VALUE}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], din};
        end
    end

    generate
        if (FILTER_DEPTH > 0 && FILTERED) begin : g_filter
            logic [FILTER_DEPTH-1:0] r_hist;
            logic                    r_held;
            logic                    w_filt;

            // Output follows only once FILTER_DEPTH consecutive samples agree.
            always_comb begin
                w_filt = r_held;
                if (&r_hist) begin
                    w_filt = 1'b1;
                end else if (~|r_hist) begin
                    w_filt = 1'b0;
                end
            end

            // Sample history plus the last accepted level.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hist <= {FILTER_DEPTH{IDLE_VALUE}};
                    r_held <= IDLE_VALUE;
                end else begin
                    for (int i = FILTER_DEPTH - 1; i > 0; i--) begin
                        r_hist[i] <= r_hist[i-1];
                    end
                    r_hist[0] <= r_chain[SYNC_STAGES-1];
                    r_held    <= w_filt;
                end
            end

            assign dout = w_filt;
        end else if (FILTER_DEPTH > 0) begin : g_delay
            logic [FILTER_DEPTH-1:0] r_dly;

            // Plain delay so this line stays aligned with the filtered ones.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dly <= {FILTER_DEPTH{IDLE_VALUE}};
                end else begin
                    for (int i = FILTER_DEPTH - 1; i > 0; i--) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                    r_dly[0] <= r_chain[SYNC_STAGES-1];
                end
            end

            assign dout = r_dly[FILTER_DEPTH-1];
        end else begin : g_bypass
            assign dout = r_chain[SYNC_STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : spi_word_receiver
//  Purpose  : SPI slave receive front end. Synchronises sclk/cs_n/mosi,
//             deserialises WIDTH-bit words in any SPI mode and offers them on
//             a valid/ready handshake. Pulses rx_overrun when a completed word
//             is dropped and rx_abort when a frame ends mid-word.
//  Config   : SPI_RX_DEBOUNCE_EN - enables the sclk/cs_n glitch filter of
//             DEBOUNCE_CYCLES stable samples.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_word_receiver
    import spi_rx_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int CPOL            = 0,
    parameter int CPHA            = 0,
    parameter int MSB_FIRST       = 1,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             rx_abort
);

    localparam int             FILTER_DELAY = DEBOUNCE_EN ? DEBOUNCE_CYCLES : 0;
    // Cycles until the synchronisers reflect the real pins after reset.
    localparam int             FLUSH_CYCLES = SYNC_STAGES + FILTER_DELAY + 1;
    localparam int             FLUSH_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES);
    localparam int             CNT_W        = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic           SAMPLE_LEVEL = sample_on_rise(CPOL, CPHA);
    localparam logic           SCLK_IDLE    = (CPOL != 0);

    logic                 w_sclk_s;
    logic                 w_cs_s;
    logic                 w_mosi_s;
    logic                 w_sample_edge;
    logic [WIDTH-1:0]     w_next_word;
    logic [WIDTH-2:0]     w_next_shift;

    rx_state_t            r_state;
    logic [FLUSH_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [WIDTH-2:0]     r_shift;
    logic                 r_sclk_prev;
    logic                 r_word_done;
    logic [WIDTH-1:0]     r_word_buf;

    spi_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_DEPTH(FILTER_DELAY),
        .FILTERED    (1'b1),
        .IDLE_VALUE  (SCLK_IDLE)
    ) u_sync_sclk (
        .clk  (clk),
        .reset(reset),
        .din  (sclk),
        .dout (w_sclk_s)
    );

    spi_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_DEPTH(FILTER_DELAY),
        .FILTERED    (1'b1),
        .IDLE_VALUE  (1'b1)
    ) u_sync_cs (
        .clk  (clk),
        .reset(reset),
        .din  (cs_n),
        .dout (w_cs_s)
    );

    // mosi gets the same total depth so its bit lines up with the sclk edge.
    spi_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_DEPTH(FILTER_DELAY),
        .FILTERED    (1'b0),
        .IDLE_VALUE  (1'b0)
    ) u_sync_mosi (
        .clk  (clk),
        .reset(reset),
        .din  (mosi),
        .dout (w_mosi_s)
    );

    assign w_sample_edge = (w_sclk_s != r_sclk_prev) && (w_sclk_s == SAMPLE_LEVEL);

    // The shift register holds WIDTH-1 bits; the final bit goes straight into
    // the completed word.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_next_word  = {r_shift, w_mosi_s};
            assign w_next_shift = w_next_word[WIDTH-2:0];
        end else begin : g_lsb_first
            assign w_next_word  = {w_mosi_s, r_shift};
            assign w_next_shift = w_next_word[WIDTH-1:1];
        end
    endgenerate

    // Frame FSM with edge detect, bit counter, shift register and abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_WAIT_IDLE;
            r_flush_cnt <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_sclk_prev <= SCLK_IDLE;
            r_word_done <= 1'b0;
            r_word_buf  <= '0;
            rx_abort    <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_word_done <= 1'b0;
            rx_abort    <= 1'b0;
            case (r_state)
                ST_WAIT_IDLE: begin
                    // Ignore the idle values preloaded by reset; only a real
                    // deasserted cs_n proves we are between frames.
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                    if (r_flush_cnt != FLUSH_LAST) begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end else if (w_cs_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (!w_cs_s) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_cs_s) begin
                        r_state   <= ST_IDLE;
                        rx_abort  <= (r_bit_cnt != '0);
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end else if (w_sample_edge) begin
                        if (r_bit_cnt == CNT_LAST) begin
                            r_word_buf  <= w_next_word;
                            r_word_done <= 1'b1;
                            r_bit_cnt   <= '0;
                            r_shift     <= '0;
                        end else begin
                            r_shift   <= w_next_shift;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_WAIT_IDLE;
            endcase
        end
    end

    // Holding register: accept a completed word when empty or draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (r_word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= r_word_buf;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_word_receiver
//  Purpose  : Self-checking bench: four 8-bit receivers (modes 0..3, mixed bit
//             order) share one serial stream; expected words and flag counts
//             come from a bit-order model kept in the bench.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_word_receiver;

    localparam int S  = 2;
    localparam int DB = 3;
    localparam int H  = 6;   // clk cycles per sclk half phase
`ifdef SPI_RX_DEBOUNCE_EN
    localparam int LAT_EXTRA = DB;
`else
    localparam int LAT_EXTRA = 0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       cs_n     = 1'b1;
    logic       mosi     = 1'b0;
    logic       phase    = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data    [4];
    logic       rx_valid   [4];
    logic       rx_overrun [4];
    logic       rx_abort   [4];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] obs_q [4][$];
    logic [7:0] exp_q [4][$];
    int         ov_cnt [4];
    int         ab_cnt [4];
    int         base_n [4];
    int         base_ov[4];
    int         base_ab[4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int P = g / 2;
        localparam int A = g % 2;
        logic sclk_g;
        assign sclk_g = phase ^ (P != 0);
        spi_word_receiver #(
            .WIDTH(8), .SYNC_STAGES(S), .CPOL(P), .CPHA(A),
            .MSB_FIRST((A == 0) ? 1 : 0), .DEBOUNCE_CYCLES(DB)
        ) u_dut (
            .clk(clk), .reset(reset), .sclk(sclk_g), .cs_n(cs_n), .mosi(mosi),
            .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready),
            .rx_overrun(rx_overrun[g]), .rx_abort(rx_abort[g])
        );
    end

    // Collect transfers and flag pulses away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (rx_valid[i] && rx_ready) obs_q[i].push_back(rx_data[i]);
                if (rx_overrun[i]) ov_cnt[i]++;
                if (rx_abort[i]) ab_cnt[i]++;
            end
        end
    end

    // Even-indexed receivers are MSB-first; odd ones place the first bit at [0].
    function automatic logic [7:0] exp_word(input int d, input logic [7:0] v);
        logic [7:0] r;
        if (d % 2 == 0) return v;
        for (int k = 0; k < 8; k++) r[k] = v[7-k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic begin_phase();
        for (int i = 0; i < 4; i++) begin
            base_n[i]  = obs_q[i].size();
            base_ov[i] = ov_cnt[i];
            base_ab[i] = ab_cnt[i];
            exp_q[i].delete();
        end
    endtask

    task automatic end_phase(input string tag, input int exp_ov, input int exp_ab, input int n_dut);
        for (int i = 0; i < n_dut; i++) begin
            int got;
            got = obs_q[i].size() - base_n[i];
            chk($sformatf("%s_dut%0d_count", tag, i), got, exp_q[i].size());
            for (int k = 0; k < exp_q[i].size() && k < got; k++)
                chk($sformatf("%s_dut%0d_word%0d", tag, i, k), obs_q[i][base_n[i]+k], exp_q[i][k]);
            chk($sformatf("%s_dut%0d_overrun", tag, i), ov_cnt[i] - base_ov[i], exp_ov);
            chk($sformatf("%s_dut%0d_abort", tag, i), ab_cnt[i] - base_ab[i], exp_ab);
        end
    endtask

    // One bit: data first, then leading and trailing sclk phases.
    task automatic send_bit(input logic b, input bit glitch, input bit lat);
        mosi = b;
        if (glitch) begin
            repeat (2) @(negedge clk);
            phase = 1'b1;
            @(negedge clk);
            phase = 1'b0;
            repeat (H - 3) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
        phase = 1'b1;
        if (lat) begin
            fork
                begin
                    repeat (H) @(negedge clk);
                end
                begin
                    @(posedge clk);
                    repeat (S + LAT_EXTRA) @(posedge clk);
                    #1 chk("latency_early", rx_valid[0], 0);
                    @(posedge clk);
                    #1 chk("latency_on_time", rx_valid[0], 1);
                end
            join
        end else begin
            repeat (H) @(negedge clk);
        end
        phase = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input int glitch_pos, input bit lat);
        logic [7:0] vv;
        vv = v;
        for (int j = 7; j >= 0; j--)
            send_bit(vv[j], (j == glitch_pos), lat && (j == 0));
        for (int i = 0; i < 4; i++) exp_q[i].push_back(exp_word(i, vv));
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    initial begin
        int nw;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_dut%0d_valid", i), rx_valid[i], 0);
            chk($sformatf("reset_dut%0d_data", i), rx_data[i], 0);
            chk($sformatf("reset_dut%0d_overrun", i), rx_overrun[i], 0);
            chk($sformatf("reset_dut%0d_abort", i), rx_abort[i], 0);
        end

        // Single word with output latency check.
        begin_phase();
        cs_low();
        send_byte(8'hA5, -1, 1'b1);
        cs_high();
        end_phase("a5", 0, 0, 4);

        // Bit-order palindrome: every mode and order yields 0x3C.
        begin_phase();
        cs_low();
        send_byte(8'h3C, -1, 1'b0);
        cs_high();
        end_phase("3c", 0, 0, 4);

        // Overrun: second word dropped while the first is held.
        begin_phase();
        rx_ready = 1'b0;
        cs_low();
        send_byte(8'h11, -1, 1'b0);
        send_byte(8'h22, -1, 1'b0);
        cs_high();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovr_dut%0d_held_valid", i), rx_valid[i], 1);
            chk($sformatf("ovr_dut%0d_held_data", i), rx_data[i], exp_word(i, 8'h11));
            void'(exp_q[i].pop_back());
        end
        @(posedge clk);
        #1 rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ovr_dut%0d_valid_after", i), rx_valid[i], 0);
        end_phase("ovr", 1, 0, 4);

        // Abort after 5 bits, then a clean frame.
        begin_phase();
        cs_low();
        for (int j = 0; j < 5; j++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        cs_high();
        end_phase("abort", 0, 1, 4);
        begin_phase();
        cs_low();
        send_byte(8'h5A, -1, 1'b0);
        cs_high();
        end_phase("5a", 0, 0, 4);

        // Reset mid-frame with cs_n held low: remainder must be ignored.
        begin_phase();
        cs_low();
        for (int j = 0; j < 3; j++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        cs_high();
        end_phase("rst_mid", 0, 0, 4);
        begin_phase();
        cs_low();
        send_byte(8'hF0, -1, 1'b0);
        cs_high();
        end_phase("f0", 0, 0, 4);

        // Random multi-word frames.
        for (int f = 0; f < 5; f++) begin
            begin_phase();
            cs_low();
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) send_byte(8'($urandom_range(0, 255)), -1, 1'b0);
            cs_high();
            end_phase($sformatf("rand%0d", f), 0, 0, 4);
        end

        // One-cycle sclk glitch during the fourth bit of 0x81.
        begin_phase();
        cs_low();
        send_byte(8'h81, 4, 1'b0);
        cs_high();
`ifdef SPI_RX_DEBOUNCE_EN
        end_phase("glitch", 0, 0, 4);
`else
        exp_q[0].delete();
        exp_q[0].push_back(8'h80);
        end_phase("glitch", 0, 1, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
